// File: rtl/step_ctrl_debounce_if.sv
// Button and step-strobe bundle between the board-facing controls and step_ctrl_debounce.
interface step_ctrl_debounce_if;
    // Strobe semantics: freq_up_o / freq_dwn_o are single-cycle, registered pulses with
    // no back-pressure. The consumer must act on every cycle a strobe is high. The two
    // strobes are never high together. The *_db_o levels are stable debounced states.
    logic       btn_up_i;
    logic       btn_dwn_i;
    logic       freq_up_o;
    logic       freq_dwn_o;
    logic       btn_up_db_o;
    logic       btn_dwn_db_o;
    logic [1:0] state_o;

    modport master (
        output btn_up_i, btn_dwn_i,
        input  freq_up_o, freq_dwn_o, btn_up_db_o, btn_dwn_db_o, state_o
    );

    modport slave (
        input  btn_up_i, btn_dwn_i,
        output freq_up_o, freq_dwn_o, btn_up_db_o, btn_dwn_db_o, state_o
    );
endinterface

// File: rtl/step_ctrl_debounce.sv
// Button front-end for blink_led frequency stepping. The path is: sync, debounce,
// up/down arbitration with lock-out, and hold-to-repeat. It produces one-cycle strobes.
module step_ctrl_debounce #(
    parameter int CLK_FREQ         = 50000000,
    parameter int DEBOUNCE_US      = 10000,
    parameter int REPEAT_DELAY_US  = 500000,
    parameter int REPEAT_PERIOD_US = 100000,
    parameter int REPEAT_EN        = 1,
    parameter int BTN_ACTIVE_LOW   = 1
) (
    input logic                 clk_i,
    input logic                 arst_i,
    step_ctrl_debounce_if.slave bus
);
    localparam int CYC_PER_US = CLK_FREQ / 1000000;
    localparam int DB_CYC     = CYC_PER_US * DEBOUNCE_US;
    localparam int RD_CYC     = CYC_PER_US * REPEAT_DELAY_US;
    localparam int RP_CYC     = CYC_PER_US * REPEAT_PERIOD_US;
    localparam int RC_CYC     = (RD_CYC > RP_CYC) ? RD_CYC : RP_CYC;
    localparam int DB_W       = $clog2(DB_CYC + 1);
    localparam int RC_W       = $clog2(RC_CYC + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD_CYC - 1);
    localparam logic [RC_W-1:0] RP_LAST = RC_W'(RP_CYC - 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(RC_CYC);
    localparam logic            INV     = (BTN_ACTIVE_LOW != 0);
    localparam logic            REP_ON  = (REPEAT_EN != 0);

    if (DB_CYC < 1 || RD_CYC < 1 || RP_CYC < 1 || (CLK_FREQ % 1000000) != 0) begin : g_bad_params
        $error("step_ctrl_debounce: every cycle constant must be >= 1 and CLK_FREQ a multiple of 1 MHz");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DWN = 2'd2, S_LOCK = 2'd3} state_t;

    // Index 0 is the "up" button and index 1 is the "down" button.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, s_q;
    logic [1:0]      db_q, db_d, db_prev_q;
    logic [DB_W-1:0] dc_q [2];
    logic [DB_W-1:0] dc_d [2];
    logic [1:0]      rise;

    state_t          state_q, state_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic            per_q, per_d;   // 0: waiting out the initial delay, 1: periodic repeats
    logic            up_q, up_d, dwn_q, dwn_d;
    logic            rep_hit;
    logic [RC_W-1:0] rc_inc;

    assign raw = {bus.btn_dwn_i, bus.btn_up_i} ^ {INV, INV};

    // Two-flop synchroniser. After the inversion, s_q reads 1 when the button is pressed.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync1_q <= '0;
            s_q     <= '0;
        end else begin
            sync1_q <= raw;
            s_q     <= sync1_q;
        end
    end

    // Debounce counters. A mismatch has to persist for DB_CYC edges before db follows.
    // The count is bounded by DB_LAST, so it can never wrap.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            dc_d[i] = dc_q[i];
            if (s_q[i] == db_q[i]) begin
                dc_d[i] = '0;
            end else if (dc_q[i] == DB_LAST) begin
                db_d[i] = s_q[i];
                dc_d[i] = '0;
            end else begin
                dc_d[i] = dc_q[i] + 1'b1;
            end
        end
    end

    // Debounced levels, their one-cycle-old copy used for press detection, and the counters.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            db_q      <= '0;
            db_prev_q <= '0;
            dc_q[0]   <= '0;
            dc_q[1]   <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            dc_q[0]   <= dc_d[0];
            dc_q[1]   <= dc_d[1];
        end
    end

    assign rise    = db_q & ~db_prev_q;
    assign rep_hit = per_q ? (rc_q == RP_LAST) : (rc_q == RD_LAST);
    assign rc_inc  = (rc_q == RC_MAX) ? rc_q : rc_q + 1'b1;

    // Arbiter and repeat next state. A release or a second button takes priority over a
    // repeat that is due on the same edge, so that repeat is dropped.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        per_d   = per_q;
        up_d    = 1'b0;
        dwn_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise[0] && db_q[1]) begin
                    state_d = S_LOCK;
                end else if (rise[1] && db_q[0]) begin
                    state_d = S_LOCK;
                end else if (rise[0]) begin
                    state_d = S_UP;
                    up_d    = 1'b1;
                    rc_d    = '0;
                    per_d   = 1'b0;
                end else if (rise[1]) begin
                    state_d = S_DWN;
                    dwn_d   = 1'b1;
                    rc_d    = '0;
                    per_d   = 1'b0;
                end
            end
            S_UP: begin
                if (db_q[1]) begin
                    state_d = S_LOCK;
                end else if (!db_q[0]) begin
                    state_d = S_IDLE;
                end else if (REP_ON && rep_hit) begin
                    up_d  = 1'b1;
                    rc_d  = '0;
                    per_d = 1'b1;
                end else begin
                    rc_d = rc_inc;
                end
            end
            S_DWN: begin
                if (db_q[0]) begin
                    state_d = S_LOCK;
                end else if (!db_q[1]) begin
                    state_d = S_IDLE;
                end else if (REP_ON && rep_hit) begin
                    dwn_d = 1'b1;
                    rc_d  = '0;
                    per_d = 1'b1;
                end else begin
                    rc_d = rc_inc;
                end
            end
            S_LOCK: begin
                if (db_q == 2'b00) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arbiter state, repeat timer, and the registered strobes.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            rc_q    <= '0;
            per_q   <= 1'b0;
            up_q    <= 1'b0;
            dwn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            per_q   <= per_d;
            up_q    <= up_d;
            dwn_q   <= dwn_d;
        end
    end

    assign bus.freq_up_o    = up_q;
    assign bus.freq_dwn_o   = dwn_q;
    assign bus.btn_up_db_o  = db_q[0];
    assign bus.btn_dwn_db_o = db_q[1];
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_step_ctrl_debounce.sv
// Bench for step_ctrl_debounce. It runs two instances side by side, one with repeat
// enabled and one with it disabled, and both see the same buttons. Strobes are matched
// against expected {kind, edge} entries. kind is 0 for up and 1 for down. The edge is the
// count of clock rises just before the strobe is sampled.
module tb_step_ctrl_debounce;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOCK = 2'd3;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_nr_q[$];

    step_ctrl_debounce_if bus ();
    step_ctrl_debounce_if bus_nr ();

    assign bus_nr.btn_up_i  = bus.btn_up_i;
    assign bus_nr.btn_dwn_i = bus.btn_dwn_i;

    step_ctrl_debounce #(
        .CLK_FREQ(1000000), .DEBOUNCE_US(8), .REPEAT_DELAY_US(50),
        .REPEAT_PERIOD_US(20), .REPEAT_EN(1), .BTN_ACTIVE_LOW(0)
    ) dut (
        .clk_i(clk), .arst_i(arst), .bus(bus.slave)
    );

    step_ctrl_debounce #(
        .CLK_FREQ(1000000), .DEBOUNCE_US(8), .REPEAT_DELAY_US(50),
        .REPEAT_PERIOD_US(20), .REPEAT_EN(0), .BTN_ACTIVE_LOW(0)
    ) dut_nr (
        .clk_i(clk), .arst_i(arst), .bus(bus_nr.slave)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor for the repeat-enabled instance.
    always @(negedge clk) begin
        logic [31:0] got, want;
        if (bus.freq_up_o || bus.freq_dwn_o) begin
            checks++;
            got = {bus.freq_dwn_o, cyc[30:0]};
            if (bus.freq_up_o && bus.freq_dwn_o) begin
                errors++;
                $display("FAIL excl_main: both strobes high at edge %0d, required at most one", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_main: got kind %0d at edge %0d, required no strobe", got[31], cyc);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL strobe_main: got kind %0d edge %0d, required kind %0d edge %0d",
                             got[31], got[30:0], want[31], want[30:0]);
                end
            end
        end
    end

    // Monitor for the repeat-disabled instance.
    always @(negedge clk) begin
        logic [31:0] got, want;
        if (bus_nr.freq_up_o || bus_nr.freq_dwn_o) begin
            checks++;
            got = {bus_nr.freq_dwn_o, cyc[30:0]};
            if (bus_nr.freq_up_o && bus_nr.freq_dwn_o) begin
                errors++;
                $display("FAIL excl_nr: both strobes high at edge %0d, required at most one", cyc);
            end else if (exp_nr_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_nr: got kind %0d at edge %0d, required no strobe", got[31], cyc);
            end else begin
                want = exp_nr_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL strobe_nr: got kind %0d edge %0d, required kind %0d edge %0d",
                             got[31], got[30:0], want[31], want[30:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b required %0b (edge %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got state %0d required %0d (edge %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_both(input logic kind, input int edge_n);
        exp_q.push_back({kind, 31'(edge_n)});
        exp_nr_q.push_back({kind, 31'(edge_n)});
    endtask

    task automatic expect_main(input logic kind, input int edge_n);
        exp_q.push_back({kind, 31'(edge_n)});
    endtask

    initial begin
        int e, r;
        bus.btn_up_i  = 1'b0;
        bus.btn_dwn_i = 1'b0;

        // Reset state
        #2;
        check_bit("rst_up", bus.freq_up_o, 1'b0);
        check_bit("rst_dwn", bus.freq_dwn_o, 1'b0);
        check_bit("rst_db_up", bus.btn_up_db_o, 1'b0);
        check_bit("rst_db_dwn", bus.btn_dwn_db_o, 1'b0);
        check_state("rst_state", bus.state_o, ST_IDLE);
        step(3);
        arst = 1'b0;
        step(5);

        // 1: clean up press
        e = cyc + 1;
        bus.btn_up_i = 1'b1;
        expect_both(1'b0, e + 10);
        wait_until(e + 8);
        check_bit("s1_db_before", bus.btn_up_db_o, 1'b0);
        step(1);
        check_bit("s1_db_rise", bus.btn_up_db_o, 1'b1);
        check_bit("s1_db_dwn", bus.btn_dwn_db_o, 1'b0);
        wait_until(e + 29);
        bus.btn_up_i = 1'b0;
        step(25);
        check_bit("s1_db_fall", bus.btn_up_db_o, 1'b0);
        check_state("s1_idle", bus.state_o, ST_IDLE);

        // 2: bounce on down, then settle high
        for (int k = 0; k < 8; k++) begin
            bus.btn_dwn_i = ((k % 2) == 0);
            step(3);
            check_bit("s2_bounce_db", bus.btn_dwn_db_o, 1'b0);
        end
        e = cyc + 1;
        bus.btn_dwn_i = 1'b1;
        expect_both(1'b1, e + 10);
        wait_until(e + 9);
        check_bit("s2_db_rise", bus.btn_dwn_db_o, 1'b1);
        wait_until(e + 29);
        bus.btn_dwn_i = 1'b0;
        step(25);

        // 3: long down hold with repeats
        e = cyc + 1;
        bus.btn_dwn_i = 1'b1;
        expect_both(1'b1, e + 10);
        expect_main(1'b1, e + 60);
        expect_main(1'b1, e + 80);
        expect_main(1'b1, e + 100);
        expect_main(1'b1, e + 120);
        wait_until(e + 125);
        bus.btn_dwn_i = 1'b0;
        wait_until(e + 134);
        check_bit("s3_db_held", bus.btn_dwn_db_o, 1'b1);
        step(1);
        check_bit("s3_db_fall", bus.btn_dwn_db_o, 1'b0);
        step(25);
        check_state("s3_idle", bus.state_o, ST_IDLE);

        // 4: simultaneous press, then a normal up press
        e = cyc + 1;
        bus.btn_up_i  = 1'b1;
        bus.btn_dwn_i = 1'b1;
        wait_until(e + 9);
        check_bit("s4_db_up", bus.btn_up_db_o, 1'b1);
        check_bit("s4_db_dwn", bus.btn_dwn_db_o, 1'b1);
        step(1);
        check_state("s4_lock", bus.state_o, ST_LOCK);
        wait_until(e + 39);
        bus.btn_up_i  = 1'b0;
        bus.btn_dwn_i = 1'b0;
        step(25);
        check_state("s4_idle", bus.state_o, ST_IDLE);
        e = cyc + 1;
        bus.btn_up_i = 1'b1;
        expect_both(1'b0, e + 10);
        wait_until(e + 19);
        bus.btn_up_i = 1'b0;
        step(25);

        // 5: lock-out by pressing down during an up repeat sequence
        e = cyc + 1;
        bus.btn_up_i = 1'b1;
        expect_both(1'b0, e + 10);
        expect_main(1'b0, e + 60);
        wait_until(e + 64);
        bus.btn_dwn_i = 1'b1;
        wait_until(e + 75);
        check_state("s5_lock", bus.state_o, ST_LOCK);
        wait_until(e + 89);
        bus.btn_dwn_i = 1'b0;
        wait_until(e + 105);
        check_state("s5_lock_hold", bus.state_o, ST_LOCK);
        check_bit("s5_db_dwn_off", bus.btn_dwn_db_o, 1'b0);
        wait_until(e + 109);
        bus.btn_up_i = 1'b0;
        wait_until(e + 125);
        check_state("s5_idle", bus.state_o, ST_IDLE);
        e = cyc + 1;
        bus.btn_dwn_i = 1'b1;
        expect_both(1'b1, e + 10);
        wait_until(e + 19);
        bus.btn_dwn_i = 1'b0;
        step(25);

        // 6: reset while up is repeating, with up held through the reset
        e = cyc + 1;
        bus.btn_up_i = 1'b1;
        expect_both(1'b0, e + 10);
        expect_main(1'b0, e + 60);
        wait_until(e + 60);
        #2;
        arst = 1'b1;
        #1;
        check_bit("s6_rst_up", bus.freq_up_o, 1'b0);
        check_bit("s6_rst_db", bus.btn_up_db_o, 1'b0);
        check_state("s6_rst_state", bus.state_o, ST_IDLE);
        check_bit("s6_rst_nr_db", bus_nr.btn_up_db_o, 1'b0);
        step(3);
        arst = 1'b0;
        r = cyc + 1;
        expect_both(1'b0, r + 10);
        wait_until(r + 9);
        check_bit("s6_db_again", bus.btn_up_db_o, 1'b1);
        wait_until(r + 29);
        bus.btn_up_i = 1'b0;
        step(25);

        // Every expected strobe should have been consumed by now.
        checks++;
        if (exp_q.size() != 0 || exp_nr_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d main and %0d nr strobes missing, required 0",
                     exp_q.size(), exp_nr_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/step_ctrl_debounce.md
# step_ctrl_debounce

Front-end for the frequency-step controls of `blink_led`. Two raw push-button inputs go through synchronisation, debouncing, press arbitration and hold-to-repeat. The block emits single-cycle `freq_up`/`freq_dwn` strobes that connect directly to `blink_led`'s `freq_up_i`/`freq_dwn_i`. Both strobes are never high in the same cycle, and no strobe is ever produced from contact bounce.

## Interface

Parameters:
- `CLK_FREQ`, default 50000000: clock frequency in Hz. Must be a multiple of 1000000.
- `DEBOUNCE_US`, default 10000: stable time, in µs, required before the debounced level changes.
- `REPEAT_DELAY_US`, default 500000: hold time, in µs, from the first strobe to the first repeat strobe.
- `REPEAT_PERIOD_US`, default 100000: interval, in µs, between subsequent repeat strobes.
- `REPEAT_EN`, default 1: 0 disables auto-repeat.
- `BTN_ACTIVE_LOW`, default 1: 1 means a button reads 0 when pressed.

Ports:
- `clk_i`, in, 1: the block's single clock.
- `arst_i`, in, 1: reset. Asynchronous, active-high.
- `btn_up_i`, in, 1: raw "up" button, asynchronous to `clk_i`.
- `btn_dwn_i`, in, 1: raw "down" button, asynchronous to `clk_i`.
- `freq_up_o`, out, 1: one-cycle step-up strobe.
- `freq_dwn_o`, out, 1: one-cycle step-down strobe.
- `btn_up_db_o`, out, 1: debounced "up" level; 1 = pressed.
- `btn_dwn_db_o`, out, 1: debounced "down" level; 1 = pressed.

## Operation

- **Cycle constants.** `X_CYC = (CLK_FREQ/1000000)*X_US` for each µs parameter. Every `X_CYC` must be ≥ 1; otherwise elaboration fails.
- **Counter widths.** Each counter is `$clog2(X_CYC+1)` bits wide and saturates; it never wraps.
- **Synchroniser.** Each button passes through 2 flops. The input is inverted when `BTN_ACTIVE_LOW`=1, so the synchronised signal `s` is 1 = pressed.
- **Debouncer, per button.**
  - `db` holds the debounced level; counter `dc` tracks stability.
  - If `s == db`: `dc` is cleared to 0.
  - Otherwise: `dc` increments. When `dc` reaches `DEBOUNCE_CYC-1` and `s` still differs, `db` takes `s` on that edge and `dc` clears.
  - Any single-cycle return of `s` to `db` restarts the count.
- **Arbiter FSM.** States: IDLE, UP, DWN, LOCK.
  - IDLE:
    - `db_up` rises and `db_dwn` is 0: go to UP and strobe up.
    - `db_dwn` rises and `db_up` is 0: go to DWN and strobe down.
    - Both rise in the same cycle, or one rises while the other is already 1: go to LOCK with no strobe.
  - UP / DWN:
    - Own `db` falls and the other is 0: go to IDLE.
    - Other `db` becomes 1: go to LOCK. The repeat sequence stops and no strobe is produced.
  - LOCK: no strobes are produced. Go to IDLE only when both `db` are 0.
- **Repeat.** Active in UP/DWN when `REPEAT_EN`=1.
  - Counter `rc` clears on the initial strobe.
  - A repeat strobe fires when `rc` reaches `REPEAT_DELAY_CYC` cycles after the initial strobe.
  - After that, a strobe fires every `REPEAT_PERIOD_CYC` cycles while the state holds.
- **Strobes.** Registered, exactly 1 cycle wide, and mutually exclusive by construction.

## Timing

- **Reset values** (while `arst_i`=1): every output is 0, sync flops are 0 (released), all `db` are 0, all counters are 0, and the FSM is in IDLE.
  - Reset takes effect immediately (asynchronous). Release is sampled on `clk_i`.
- **Button held through reset.** The button is treated as a fresh press after release, and a strobe follows after the normal press latency.
- **Press latency.** A raw level change that is stable from clock edge E gives:
  - `db` changes at edge E+1+`DEBOUNCE_CYC`;
  - the strobe is high during the cycle after edge E+2+`DEBOUNCE_CYC`.
- **Release latency.** `db` falls `DEBOUNCE_CYC`+1 edges after the raw release. FSM exit takes effect on the following edge.
- **Repeat strobes.** Cycle offsets from the initial strobe are `REPEAT_DELAY_CYC`, then `+REPEAT_PERIOD_CYC`, `+2·REPEAT_PERIOD_CYC`, and so on.
- **Release on a repeat edge.** If own `db` falls on the same edge a repeat would fire, the repeat is suppressed.
- **Debounced outputs.** `btn_*_db_o` are the `db` registers themselves, with no extra delay.

## Test plan

All scenarios use `CLK_FREQ`=1000000, `DEBOUNCE_US`=8, `REPEAT_DELAY_US`=50, `REPEAT_PERIOD_US`=20, `BTN_ACTIVE_LOW`=0.

1. **Clean press.** `btn_up_i` rises cleanly and is held 30 cycles, then released. Required: `btn_up_db_o` rises 9 edges after the rise; exactly one `freq_up_o` pulse, 1 cycle wide, 10 edges after the rise; `freq_dwn_o` stays 0.
2. **Bounce.** `btn_dwn_i` toggles every 3 cycles for 24 cycles, then settles high. Required: no `freq_dwn_o` during the bouncing; a single pulse 10 edges after the settle edge.
3. **Repeat.** `btn_dwn_i` is held so that `btn_dwn_db_o` stays high for 125 cycles after the initial strobe (t0). Required: `freq_dwn_o` pulses at t0, t0+50, t0+70, t0+90, t0+110 (5 pulses), then none; the same test with `REPEAT_EN`=0 gives only the t0 pulse.
4. **Simultaneous press.** Both buttons rise on the same cycle and are held 40 cycles. Required: both `db` outputs go to 1, no strobes at all; after both are released, an up press gives a normal single pulse.
5. **Lock-out.** Up is held through one repeat, then down is pressed. Required: no further strobes of either kind; releasing down alone still gives no strobes; after up is also released, a fresh down press gives one `freq_dwn_o`.
6. **Reset mid-operation.** `arst_i` is pulsed mid-hold on up, during repeats. Required: all outputs are 0 within the same cycle; with up still held after release, `freq_up_o` pulses 10 edges after the reset-release edge.
